// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time IMEM loader.
package rida_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         HDR_LEN       = 2;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write bus of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master: byte source / IMEM observer; slave: the loader itself
    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_word_asm.sv
// Assembles four MSB-first bytes into a 32-bit word and pulses word_ready
// for one cycle after the fourth byte, while the word is still held.
module loader_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_last,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] sr_q, sr_d;
    logic        word_ready_q, word_ready_d;

    always_comb begin
        lane_d       = lane_q;
        sr_d         = sr_q;
        word_ready_d = 1'b0;
        word_last    = byte_en && (lane_q == 2'd3);
        if (clr) begin
            lane_d = 2'd0;
            sr_d   = 32'd0;
        end else if (byte_en) begin
            lane_d       = lane_q + 2'd1;
            sr_d         = {sr_q[23:0], byte_in};
            word_ready_d = word_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q       <= 2'd0;
            sr_q         <= 32'd0;
            word_ready_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            sr_q         <= sr_d;
            word_ready_q <= word_ready_d;
        end
    end

    assign word       = sr_q;
    assign word_ready = word_ready_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC/N/payload/CS frames, writes words to IMEM and
// releases the CPU reset only once the payload checksum verifies.
module imem_loader
    import rida_loader_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    loader_state_e     state_q, state_d;
    logic [7:0]        n_hi_q, n_hi_d;
    logic [15:0]       words_left_q, words_left_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [7:0]        cs_q, cs_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic        acc, is_sync, asm_clr, asm_en, word_last, asm_ready;
    logic [31:0] asm_word;
    logic [16:0] n_full;

    // Word assembly writes through its own register, so input is never stalled.
    assign bus.rx_ready = rst;
    assign acc          = bus.rx_valid && bus.rx_ready;
    assign is_sync      = (bus.rx_data == SYNC_BYTE);
    assign n_full       = {1'b0, n_hi_q, bus.rx_data};
    assign asm_en       = acc && (state_q == ST_LOAD);

    loader_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (asm_clr),
        .byte_en    (asm_en),
        .byte_in    (bus.rx_data),
        .word_last  (word_last),
        .word       (asm_word),
        .word_ready (asm_ready)
    );

    always_comb begin
        state_d      = state_q;
        n_hi_d       = n_hi_q;
        words_left_d = words_left_q;
        ptr_d        = ptr_q;
        imem_addr_d  = imem_addr_q;
        cs_d         = cs_q;
        cpu_rst_d    = cpu_rst_q;
        done_d       = done_q;
        error_d      = error_q;
        asm_clr      = 1'b0;
        case (state_q)
            ST_IDLE: if (acc && is_sync) state_d = ST_HDR_HI;
            ST_HDR_HI: if (acc) begin
                n_hi_d  = bus.rx_data;
                state_d = ST_HDR_LO;
            end
            ST_HDR_LO: if (acc) begin
                cs_d = 8'd0;
                if (n_full > DEPTH) begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end else if (n_full == 17'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d      = ST_LOAD;
                    words_left_d = n_full[15:0];
                    ptr_d        = '0;
                    asm_clr      = 1'b1;
                end
            end
            ST_LOAD: if (acc) begin
                cs_d = cs_q ^ bus.rx_data;
                if (word_last) begin
                    imem_addr_d  = ptr_q;
                    ptr_d        = ptr_q + ADDR_W'(1);
                    words_left_d = words_left_q - 16'd1;
                    if (words_left_q == 16'd1) state_d = ST_CHECK;
                end
            end
            ST_CHECK: if (acc) begin
                if (bus.rx_data == cs_q) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b1;
                end else begin
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                end
            end
            ST_DONE: if (acc && is_sync) begin
                state_d   = ST_HDR_HI;
                done_d    = 1'b0;
                cpu_rst_d = 1'b0;
            end
            ST_ERROR: if (acc && is_sync) begin
                state_d = ST_HDR_HI;
                error_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            n_hi_q       <= 8'd0;
            words_left_q <= 16'd0;
            ptr_q        <= '0;
            imem_addr_q  <= '0;
            cs_q         <= 8'd0;
            cpu_rst_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_hi_q       <= n_hi_d;
            words_left_q <= words_left_d;
            ptr_q        <= ptr_d;
            imem_addr_q  <= imem_addr_d;
            cs_q         <= cs_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.imem_we    = asm_ready;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = asm_word;
    assign cpu_rst        = cpu_rst_q;
    assign done           = done_q;
    assign error          = error_q;
    assign busy           = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                            (state_q == ST_LOAD)   || (state_q == ST_CHECK);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a scoreboard of expected IMEM writes.
module tb_imem_loader;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam logic [7:0] CS_GOOD = 8'h45;
    localparam logic [7:0] CS_BAD  = 8'h46;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_rst, busy, done, error;
    int   tests = 0;
    int   fails = 0;
    wr_t  exp_q[$];
    wr_t  obs_q[$];

    imem_loader_if #(.ADDR_W(10)) bus ();

    imem_loader #(.ADDR_W(10), .SYNC_BYTE(SYNC)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && bus.imem_we) obs_q.push_back('{addr: bus.imem_addr, data: bus.imem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drain_check(input string tag);
        wr_t e, o;
        check({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_addr"}, 32'(o.addr), 32'(e.addr));
            check({tag, "_data"}, o.data, e.data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Drive one byte, accepted at the next posedge; return #1 after an edge.
    task automatic send(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame2(input logic [7:0] cs, input int maxgap);
        logic [31:0] w [2];
        logic [31:0] cur;
        w[0] = 32'h1122_3344;
        w[1] = 32'h0000_0001;
        send(SYNC, $urandom_range(0, maxgap));
        send(8'h00, $urandom_range(0, maxgap));
        send(8'h02, $urandom_range(0, maxgap));
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{addr: 10'(i), data: w[i]});
            cur = w[i];
            for (int b = 0; b < 4; b++) begin
                send(cur[31:24], $urandom_range(0, maxgap));
                cur = cur << 8;
            end
        end
        send(cs, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 0);
        check({tag, "_imem_we"},  32'(bus.imem_we), 0);
        check({tag, "_imem_addr"}, 32'(bus.imem_addr), 0);
        check({tag, "_imem_wdata"}, bus.imem_wdata, 0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 0);
        check({tag, "_busy"},    32'(busy), 0);
        check({tag, "_done"},    32'(done), 0);
        check({tag, "_error"},   32'(error), 0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;
        #1;
        check("rx_ready_after_reset", 32'(bus.rx_ready), 1);
        @(posedge clk);
        #1;

        // 1: valid frame
        send(SYNC, 0);
        check("s1_busy_hdr", 32'(busy), 1);
        send(8'h00, 0);
        send(8'h02, 0);
        exp_q.push_back('{addr: 10'd0, data: 32'h1122_3344});
        exp_q.push_back('{addr: 10'd1, data: 32'h0000_0001});
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
        check("s1_done_before_cs", 32'(done), 0);
        check("s1_cpu_rst_before_cs", 32'(cpu_rst), 0);
        send(CS_GOOD, 0);
        check("s1_done", 32'(done), 1);
        check("s1_cpu_rst", 32'(cpu_rst), 1);
        check("s1_error", 32'(error), 0);
        check("s1_busy", 32'(busy), 0);
        repeat (2) begin @(posedge clk); #1; end
        check("s1_addr_hold", 32'(bus.imem_addr), 1);
        drain_check("s1");

        // 2: bad checksum, then recovery
        frame2(CS_BAD, 0);
        check("s2_error", 32'(error), 1);
        check("s2_cpu_rst", 32'(cpu_rst), 0);
        check("s2_done", 32'(done), 0);
        drain_check("s2");
        send(8'h33, 0);
        check("s2_error_sticky", 32'(error), 1);
        frame2(CS_GOOD, 0);
        check("s2_recover_done", 32'(done), 1);
        check("s2_recover_error", 32'(error), 0);
        drain_check("s2_recover");

        // 3: garbage then frame with bubbles
        send(8'h00, 1); send(8'hFF, 0); send(8'h5A, 2);
        check("s3_garbage_done", 32'(done), 1);
        check("s3_garbage_busy", 32'(busy), 0);
        frame2(CS_GOOD, 3);
        check("s3_done", 32'(done), 1);
        check("s3_cpu_rst", 32'(cpu_rst), 1);
        check("s3_error", 32'(error), 0);
        drain_check("s3");

        // 4: oversize count
        send(SYNC, 0); send(8'h04, 0); send(8'h01, 0);
        check("s4_error", 32'(error), 1);
        check("s4_busy", 32'(busy), 0);
        check("s4_done", 32'(done), 0);
        check("s4_cpu_rst", 32'(cpu_rst), 0);
        drain_check("s4");

        // 5: reset mid-load
        send(SYNC, 0); send(8'h00, 0); send(8'h02, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        check("s5_busy_midload", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check_idle_outputs("s5_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        frame2(CS_GOOD, 0);
        check("s5_done", 32'(done), 1);
        drain_check("s5");

        // 6: empty frame, then reload from DONE
        send(SYNC, 0); send(8'h00, 0); send(8'h00, 0);
        check("s6_busy_check", 32'(busy), 1);
        send(8'h00, 0);
        check("s6_done", 32'(done), 1);
        check("s6_cpu_rst", 32'(cpu_rst), 1);
        drain_check("s6");
        send(SYNC, 0);
        check("s6_reload_cpu_rst", 32'(cpu_rst), 0);
        check("s6_reload_done", 32'(done), 0);
        check("s6_reload_busy", 32'(busy), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
